// File: rtl/ats21_pkg.sv
// Shared types and defaults for the ATS21 host controller and its alarm capture.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ats21_pkg;

   localparam int DEF_RDY_TIMEOUT = 15;
   localparam int DEF_STAT_LAT    = 2;
   localparam int DEF_NUM_ALARMS  = 24;

   // Host transaction sequencer states
   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_RDY,
      SEND_HI,
      SEND_LO,
      WAIT_STAT,
      RESP
   } state_t;

   // ATS21 instruction opcodes
   typedef enum logic [2:0] {
      NOP     = 3'b000,
      SET_CLK = 3'b001,
      EN_CLK  = 3'b010,
      MODE    = 3'b011,
      SET_ALM = 3'b101,
      SET_TMR = 3'b110,
      EN_ALM  = 3'b111
   } opcode_t;

endpackage

// File: rtl/ats21_alarm_capture.sv
// Sticky rising-edge capture of ATS21 alarm lines with a registered interrupt.
// Latency: evt sets 1 cycle after a 0->1 on ats_data; irq follows evt by 1 cycle.
// Backpressure: none; runs every cycle regardless of the host sequencer.
module ats21_alarm_capture
   import ats21_pkg::*;
#(
   parameter int NUM_ALARMS = DEF_NUM_ALARMS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_ALARMS-1:0] ats_data,
   input  logic [NUM_ALARMS-1:0] alarm_clr,
   output logic [NUM_ALARMS-1:0] alarm_evt,
   output logic                  alarm_irq
);

   logic [NUM_ALARMS-1:0] data_q;
   logic [NUM_ALARMS-1:0] evt_q, evt_d;
   logic                  irq_q;

   // Clear first, then OR in new rising edges so a same-cycle edge wins
   always_comb begin
      evt_d = (evt_q & ~alarm_clr) | (ats_data & ~data_q);
   end

   // Data history, sticky events and interrupt registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         evt_q  <= '0;
         irq_q  <= 1'b0;
      end else begin
         data_q <= ats_data;
         evt_q  <= evt_d;
         irq_q  <= |evt_q;
      end
   end

   assign alarm_evt = evt_q;
   assign alarm_irq = irq_q;

endmodule

// File: rtl/ats21_host.sv
// Host sequencer: takes one command pair, handshakes with the ATS21, returns acks/timeout.
// Latency: REQ + ready wait (<= RDY_TIMEOUT) + 2 ctrl words + STAT_LAT, then response.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready.
module ats21_host
   import ats21_pkg::*;
#(
   parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT,
   parameter int STAT_LAT    = DEF_STAT_LAT,
   parameter int NUM_ALARMS  = DEF_NUM_ALARMS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [31:0]           cmd_a,
   input  logic [31:0]           cmd_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_ack_a,
   output logic                  rsp_ack_b,
   output logic                  rsp_timeout,
   output logic                  ats_req,
   output logic [15:0]           ats_ctrlA,
   output logic [15:0]           ats_ctrlB,
   input  logic                  ats_ready,
   input  logic [1:0]            ats_stat,
   input  logic [NUM_ALARMS-1:0] ats_data,
   output logic [NUM_ALARMS-1:0] alarm_evt,
   input  logic [NUM_ALARMS-1:0] alarm_clr,
   output logic                  alarm_irq
);

   localparam int WW = $clog2(RDY_TIMEOUT + 1);
   localparam int SW = $clog2(STAT_LAT + 1);
   localparam logic [WW-1:0] W_LAST = WW'(RDY_TIMEOUT - 1);
   localparam logic [WW-1:0] W_MAX  = WW'(RDY_TIMEOUT);
   localparam logic [SW-1:0] S_LAST = SW'(STAT_LAT - 1);

   state_t        state_q, state_d;
   logic [31:0]   cmd_a_q, cmd_a_d;
   logic [31:0]   cmd_b_q, cmd_b_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic          ack_a_q, ack_a_d;
   logic          ack_b_q, ack_b_d;
   logic          tmo_q, tmo_d;
   logic          live_q;

   // Next-state, datapath updates and Moore outputs
   always_comb begin
      state_d   = state_q;
      cmd_a_d   = cmd_a_q;
      cmd_b_d   = cmd_b_q;
      wcnt_d    = wcnt_q;
      scnt_d    = scnt_q;
      ack_a_d   = ack_a_q;
      ack_b_d   = ack_b_q;
      tmo_d     = tmo_q;
      cmd_ready = 1'b0;
      ats_req   = 1'b0;
      ats_ctrlA = 16'h0000;
      ats_ctrlB = 16'h0000;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            // live_q keeps cmd_ready low until the first edge out of reset
            cmd_ready = live_q;
            if (cmd_valid && live_q) begin
               cmd_a_d = cmd_a;
               cmd_b_d = cmd_b;
               ack_a_d = 1'b0;
               ack_b_d = 1'b0;
               tmo_d   = 1'b0;
               state_d = REQ;
            end
         end
         REQ: begin
            ats_req = 1'b1;
            wcnt_d  = '0;
            // A ready that arrives alongside the request is honoured
            state_d = ats_ready ? SEND_HI : WAIT_RDY;
         end
         WAIT_RDY: begin
            if (ats_ready) begin
               state_d = SEND_HI;
            end else if (wcnt_q == W_LAST) begin
               tmo_d   = 1'b1;
               state_d = RESP;
            end else if (wcnt_q != W_MAX) begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         SEND_HI: begin
            ats_ctrlA = cmd_a_q[31:16];
            ats_ctrlB = cmd_b_q[31:16];
            state_d   = SEND_LO;
         end
         SEND_LO: begin
            ats_ctrlA = cmd_a_q[15:0];
            ats_ctrlB = cmd_b_q[15:0];
            scnt_d    = '0;
            state_d   = WAIT_STAT;
         end
         WAIT_STAT: begin
            if (scnt_q == S_LAST) begin
               ack_a_d = ats_stat[0];
               ack_b_d = ats_stat[1];
               state_d = RESP;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latched command, counters and response payload
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cmd_a_q <= '0;
         cmd_b_q <= '0;
         wcnt_q  <= '0;
         scnt_q  <= '0;
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         tmo_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_a_q <= cmd_a_d;
         cmd_b_q <= cmd_b_d;
         wcnt_q  <= wcnt_d;
         scnt_q  <= scnt_d;
         ack_a_q <= ack_a_d;
         ack_b_q <= ack_b_d;
         tmo_q   <= tmo_d;
         live_q  <= 1'b1;
      end
   end

   assign rsp_ack_a   = ack_a_q;
   assign rsp_ack_b   = ack_b_q;
   assign rsp_timeout = tmo_q;

   ats21_alarm_capture #(
      .NUM_ALARMS (NUM_ALARMS)
   ) u_alarm (
      .clk       (clk),
      .reset     (reset),
      .ats_data  (ats_data),
      .alarm_clr (alarm_clr),
      .alarm_evt (alarm_evt),
      .alarm_irq (alarm_irq)
   );

endmodule

// File: tb/tb_ats21_host.sv
// Randomized bench for ats21_host with a transaction-timeline model and alarm model.
// Latency: checks every cycle against expected timeline derived from ready delay.
// Backpressure: exercises rsp_ready stalls and command hold-off.
module tb_ats21_host;

   localparam int NA  = 24;
   localparam int TMO = 15;
   localparam int SL  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [31:0]   cmd_a, cmd_b;
   logic          rsp_valid, rsp_ready;
   logic          rsp_ack_a, rsp_ack_b, rsp_timeout;
   logic          ats_req;
   logic [15:0]   ats_ctrlA, ats_ctrlB;
   logic          ats_ready;
   logic [1:0]    ats_stat;
   logic [NA-1:0] ats_data, alarm_evt, alarm_clr;
   logic          alarm_irq;

   always #5 clk = ~clk;

   ats21_host dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_ack_a   (rsp_ack_a),
      .rsp_ack_b   (rsp_ack_b),
      .rsp_timeout (rsp_timeout),
      .ats_req     (ats_req),
      .ats_ctrlA   (ats_ctrlA),
      .ats_ctrlB   (ats_ctrlB),
      .ats_ready   (ats_ready),
      .ats_stat    (ats_stat),
      .ats_data    (ats_data),
      .alarm_evt   (alarm_evt),
      .alarm_clr   (alarm_clr),
      .alarm_irq   (alarm_irq)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Alarm reference: sticky per-line event flags and a delayed interrupt
   logic [NA-1:0] m_prev, m_evt;
   logic          m_irq;
   bit            alarm_rand;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      logic [NA-1:0] nxt_evt;
      logic          nxt_irq;
      nxt_irq = |m_evt;
      for (int i = 0; i < NA; i++) begin
         nxt_evt[i] = m_evt[i];
         if (alarm_clr[i]) nxt_evt[i] = 1'b0;
         if (ats_data[i] && !m_prev[i]) nxt_evt[i] = 1'b1;
      end
      @(posedge clk);
      if (reset) begin
         m_evt = '0; m_prev = '0; m_irq = 1'b0;
      end else begin
         m_prev = ats_data; m_evt = nxt_evt; m_irq = nxt_irq;
      end
      #1;
      chk("alarm_evt", 32'(alarm_evt), 32'(m_evt));
      chk("alarm_irq", 32'(alarm_irq), 32'(m_irq));
      if (alarm_rand) begin
         ats_data  = ats_data ^ (NA'($urandom) & NA'($urandom) & NA'($urandom));
         alarm_clr = NA'($urandom) & NA'($urandom);
      end
   endtask

   // d = cycle index (0 = REQ cycle) of the single ats_ready pulse; d > TMO means never
   task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int d,
                          input logic [1:0] stat, input int rdly);
      int          resp_t;
      bit          tmo;
      logic [15:0] ea, eb;
      tmo    = (d > TMO);
      resp_t = tmo ? TMO + 1 : d + 3 + SL;
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
      step();
      cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom;
      for (int t = 0; t < resp_t; t++) begin
         ats_ready = (t < d) ? 1'b0 : (t == d) ? 1'b1 : 1'($urandom);
         ats_stat  = (!tmo && t == d + 2 + SL) ? stat : 2'($urandom);
         ea = 16'h0; eb = 16'h0;
         if (!tmo && t == d + 1) begin ea = a[31:16]; eb = b[31:16]; end
         if (!tmo && t == d + 2) begin ea = a[15:0];  eb = b[15:0];  end
         #1;
         chk("ats_req",        32'(ats_req),   32'(t == 0));
         chk("ats_ctrlA",      32'(ats_ctrlA), 32'(ea));
         chk("ats_ctrlB",      32'(ats_ctrlB), 32'(eb));
         chk("busy_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
         step();
      end
      for (int k = 0; k <= rdly; k++) begin
         rsp_ready = (k == rdly);
         ats_ready = 1'($urandom);
         ats_stat  = 2'($urandom);
         #1;
         chk("rsp_valid",     32'(rsp_valid),   32'd1);
         chk("rsp_ack_a",     32'(rsp_ack_a),   32'(tmo ? 1'b0 : stat[0]));
         chk("rsp_ack_b",     32'(rsp_ack_b),   32'(tmo ? 1'b0 : stat[1]));
         chk("rsp_timeout",   32'(rsp_timeout), 32'(tmo));
         chk("rsp_cmd_ready", 32'(cmd_ready),   32'd0);
         chk("rsp_ctrlA",     32'(ats_ctrlA),   32'd0);
         step();
      end
      rsp_ready = 1'b0;
      #1;
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      ats_ready = 1'b0; ats_stat = '0; ats_data = '0; alarm_clr = '0;
      alarm_rand = 1'b0; m_prev = '0; m_evt = '0; m_irq = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready",   32'(cmd_ready),   32'd0);
      chk("rst_ats_req",     32'(ats_req),     32'd0);
      chk("rst_ctrlA",       32'(ats_ctrlA),   32'd0);
      chk("rst_ctrlB",       32'(ats_ctrlB),   32'd0);
      chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
      chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("rst_alarm_evt",   32'(alarm_evt),   32'd0);
      chk("rst_alarm_irq",   32'(alarm_irq),   32'd0);
      reset = 1'b0;
      #1;
      chk("rel_cmd_ready_pre", 32'(cmd_ready), 32'd0);
      step();
      chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

      // Directed transactions
      run_txn(32'h6F000000, 32'h00000000, 1, 2'b01, 0);
      run_txn($urandom, $urandom, 99, 2'b11, 0);
      run_txn($urandom, $urandom, 3, 2'b10, 5);
      run_txn($urandom, $urandom, 0, 2'b11, 1);
      run_txn($urandom, $urandom, TMO, 2'b01, 0);
      run_txn($urandom, $urandom, TMO + 1, 2'b11, 2);

      // Directed alarm: set wins over same-cycle clear, later clear alone drops it
      ats_data = '0; alarm_clr = '0;
      step(); step();
      ats_data[3] = 1'b1; alarm_clr[3] = 1'b1;
      step();
      chk("dir_evt3_set", 32'(alarm_evt[3]), 32'd1);
      alarm_clr = '0;
      step();
      chk("dir_irq_set", 32'(alarm_irq), 32'd1);
      alarm_clr[3] = 1'b1;
      step();
      chk("dir_evt3_clr", 32'(alarm_evt[3]), 32'd0);
      alarm_clr = '0;
      step();
      chk("dir_irq_clr", 32'(alarm_irq), 32'd0);

      // Reset while in SEND_LO
      ra = 32'hA5A51234; rb = 32'h5A5AFEDC;
      cmd_valid = 1'b1; cmd_a = ra; cmd_b = rb;
      step();
      cmd_valid = 1'b0; ats_ready = 1'b1;
      step();
      ats_ready = 1'b0;
      chk("mid_ctrlA_hi", 32'(ats_ctrlA), 32'(ra[31:16]));
      step();
      chk("mid_ctrlB_lo", 32'(ats_ctrlB), 32'(rb[15:0]));
      reset = 1'b1;
      m_evt = '0; m_prev = '0; m_irq = 1'b0;
      #1;
      chk("mid_rst_ctrlA",     32'(ats_ctrlA), 32'd0);
      chk("mid_rst_ctrlB",     32'(ats_ctrlB), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_alarm_evt", 32'(alarm_evt), 32'd0);
      chk("mid_rst_alarm_irq", 32'(alarm_irq), 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         ats_ready = 1'($urandom); ats_stat = 2'($urandom);
         step();
         chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      end
      run_txn($urandom, $urandom, 2, 2'b10, 1);

      // Randomized traffic with alarm activity in the background
      alarm_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         run_txn($urandom, $urandom, int'($urandom_range(0, 20)), 2'($urandom),
                 int'($urandom_range(0, 3)));
      end
      alarm_rand = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
